uart_rx_ovs: RTL and testbench
==============================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_DIV, 27, i_clk cycles per oversample tick (16 ticks per bit; 50 MHz / (16*115200) ≈ 27); legal values are 2..4095.
REQ-002 SHALL have parameter DATA_BITS, 8, data bits per frame; legal values are 5..9.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, receive FIFO entries; legal values are powers of 2 from 2 to 64.
REQ-004 SHALL have parameter PARITY_ODD, 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_rx  input  1  asynchronous serial line; idle level is high.
REQ-008 SHALL have port o_data  output  DATA_BITS  FIFO head word, LSB = first received bit.
REQ-009 SHALL have port o_data_valid  output  1  FIFO not empty.
REQ-010 SHALL have port i_data_ready  input  1  consumer accepts the head word.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port o_parity_err  output  1  one-cycle pulse when a parity check fails.
REQ-013 SHALL have port o_overrun  output  1  one-cycle pulse when a good word is dropped because the FIFO is full.
REQ-014 SHALL have port o_busy  output  1  high while the state machine is not in IDLE.
REQ-015 SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words currently held.

Function
REQ-016 SHALL pass i_rx through a 2-FF synchronizer whose flops reset to 1; all further logic uses the synchronized value.
REQ-017 SHALL generate a one-cycle tick every CLK_DIV clocks; the tick counter resets to 0 and restarts on each IDLE-to-START transition.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick-in-bit counter and a bit index.
REQ-019 SHALL leave IDLE only on a high-to-low transition of the synchronized line; a line held low (break) does not retrigger.
REQ-020 SHALL sample each bit at ticks 7, 8 and 9 and take the 2-of-3 majority as the bit value.
REQ-021 SHALL return from START to IDLE with no flag if the START majority is 1 (glitch rejection).
REQ-022 SHALL shift DATA bits LSB first; after bit DATA_BITS-1 it goes to PARITY if compiled in, otherwise to STOP.
REQ-023 SHALL, in STOP, decide at tick 9: on majority 1, push the word; on majority 0, pulse o_frame_err and discard the word; either way go to IDLE on the next clock.
REQ-024 SHALL, on a push, make o_data_valid rise on the clock after the stop-decision clock.
REQ-025 SHALL present the FIFO as first-word-fall-through: a pop occurs on every clock where o_data_valid and i_data_ready are both high.
REQ-026 SHALL accept a push while the FIFO is full only if a pop occurs in the same cycle; otherwise it drops the new word, pulses o_overrun and leaves the FIFO contents unchanged.
REQ-027 SHALL leave o_fifo_count unchanged on a simultaneous push and pop; the pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL hold o_data stable while o_data_valid is high and no pop has occurred.

Reset
REQ-029 SHALL, on i_rst at any time (including mid-frame), go to IDLE, empty the FIFO, set o_data_valid, o_frame_err, o_parity_err, o_overrun and o_busy to 0, set o_fifo_count and o_data to 0, and set the synchronizer flops to 1.
REQ-030 SHALL, after reset release, require a fresh high-to-low edge before receiving; a partial frame in progress at reset is not recovered.

Configuration
REQ-031 SHALL, when UART_RX_PARITY_EN is defined, include the PARITY state: one parity bit is sampled by majority, checked as even (PARITY_ODD=0) or odd (PARITY_ODD=1), and on mismatch the word is discarded with an o_parity_err pulse at the parity decision, while STOP still runs.
REQ-032 SHALL, when UART_RX_PARITY_EN is undefined, omit the PARITY state, keep the o_parity_err port and tie it to 0, and ignore PARITY_ODD.

Structure
REQ-033 SHALL place the state-encoding enum, the OVS_RATE=16 and SAMPLE_MID=8 constants, and the parameter legality checks in the shared package uart_pkg.
REQ-034 SHALL implement the FIFO as the sub-module uart_fifo, parametrised by width and depth, with push/pop/full/empty/count ports.

Verification
REQ-035 SHALL cover: CLK_DIV=4, DATA_BITS=8, frame 0xA5 with good stop, i_data_ready=1 -> o_data=0xA5 with o_data_valid high for 1 clock, and no flags.
REQ-036 SHALL cover: a 3-tick low glitch on an idle line -> the machine returns to IDLE, with no push and no flags.
REQ-037 SHALL cover: frame 0x3C with stop bit low -> o_frame_err pulses once, o_fifo_count stays 0, and the next valid frame 0x11 is received.
REQ-038 SHALL cover: FIFO_DEPTH=4 with i_data_ready=0 and 5 frames 0x01..0x05 -> o_fifo_count=4 and one o_overrun pulse; draining then yields 0x01..0x04.
REQ-039 SHALL cover: with UART_RX_PARITY_EN and PARITY_ODD=0, frame 0x07 with parity bit 0 -> o_parity_err pulses and no push; with parity bit 1 -> 0x07 is received.
REQ-040 SHALL cover: i_rst asserted during DATA bit 4 -> all outputs go to 0 immediately, and a subsequent frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// oversampling constants, parameter legality checks and the majority voter.
package uart_pkg;

    localparam int OVS_RATE   = 16;
    localparam int SAMPLE_MID = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // 2-of-3 majority of the samples taken around mid-bit
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when every configuration parameter lies in its legal range
    function automatic bit params_ok(input int clk_div, input int data_bits,
                                     input int fifo_depth, input int parity_odd);
        bit ok;
        ok = (clk_div >= 2) && (clk_div <= 4095);
        ok = ok && (data_bits >= 5) && (data_bits <= 9);
        ok = ok && (fifo_depth >= 2) && (fifo_depth <= 64);
        ok = ok && ((fifo_depth & (fifo_depth - 1)) == 0);
        ok = ok && ((parity_odd == 0) || (parity_odd == 1));
        return ok;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for received words. A push into a full FIFO
// is accepted only when a pop happens in the same cycle. Storage is not
// reset; the head output is forced to zero while the FIFO is empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver with majority-vote bit sampling and a
// first-word-fall-through receive FIFO.
// Optional parity checking is compiled in by defining UART_RX_PARITY_EN;
// without it the PARITY state is skipped and o_parity_err stays low.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_rx,
    output logic [DATA_BITS-1:0]              o_data,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    output logic                              o_frame_err,
    output logic                              o_parity_err,
    output logic                              o_overrun,
    output logic                              o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

    localparam bit PARAMS_OK = params_ok(CLK_DIV, DATA_BITS, FIFO_DEPTH, PARITY_ODD);
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int BIT_W     = $clog2(DATA_BITS);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("uart_rx_ovs: illegal parameter value");
        end
    endgenerate

    // synchronizer (p0, p1) and previous synchronized value (p2)
    logic                 rx_p0;
    logic                 rx_p1;
    logic                 rx_p2;

    rx_state_t            state;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           tick_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 par_bad;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;

    logic                 fall;
    logic                 tick;
    logic                 at_dec;
    logic                 at_end;
    logic                 bit_val;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign fall     = rx_p2 & ~rx_p1;
    assign tick     = (state != ST_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign at_dec   = tick && (tick_cnt == 4'(SAMPLE_MID + 1));
    assign at_end   = tick && (tick_cnt == 4'(OVS_RATE - 1));
    assign bit_val  = maj3(samp[0], samp[1], rx_p1);
    assign push_req = (state == ST_STOP) && at_dec && bit_val && !par_bad;
    assign pop      = o_data_valid & i_data_ready;

    // Line synchronizer; flops idle high so reset never looks like a start edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= i_rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // Receive state machine with tick divider, bit timing and status pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= push_req & fifo_full & ~pop;
            if (state == ST_IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_idx  <= '0;
                if (fall) begin
                    state   <= ST_START;
                    par_bad <= 1'b0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= tick_cnt + 1'b1;
                case (state)
                    ST_START: begin
                        if (at_dec && bit_val) begin
                            state <= ST_IDLE;
                        end else if (at_end) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (at_end) begin
                            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (at_dec && ((^shreg ^ bit_val) != 1'(PARITY_ODD))) begin
                            par_bad    <= 1'b1;
                            parity_err <= 1'b1;
                        end
                        if (at_end) state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (at_dec) begin
                            if (!bit_val) frame_err <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Mid-bit samples and data shift register (LSB received first)
    always_ff @(posedge i_clk) begin
        if (tick) begin
            if (tick_cnt == 4'(SAMPLE_MID - 1)) samp[0] <= rx_p1;
            if (tick_cnt == 4'(SAMPLE_MID))     samp[1] <= rx_p1;
            if ((state == ST_DATA) && at_dec)
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push_req),
        .din   (shreg),
        .pop   (pop),
        .dout  (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    assign o_data_valid = ~fifo_empty;
    assign o_frame_err  = frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err;
`else
    assign o_parity_err = 1'b0;
`endif
    assign o_overrun    = overrun;
    assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs (CLK_DIV=4, 8 data bits, 4-deep FIFO).
module tb_uart_rx_ovs;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = CLK_DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                              i_clk = 1'b0;
    logic                              i_rst;
    logic                              i_rx;
    logic                              i_data_ready;
    logic [DATA_BITS-1:0]              o_data;
    logic                              o_data_valid;
    logic                              o_frame_err;
    logic                              o_parity_err;
    logic                              o_overrun;
    logic                              o_busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count;

    int errors = 0;
    int checks = 0;
    int n_ferr, n_perr, n_ovr, n_vld;
    logic [7:0] got_q [$];

    always #5 i_clk = ~i_clk;

    uart_rx_ovs #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy),
        .o_fifo_count (o_fifo_count)
    );

    // Observe pulses and consumed words between active edges
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_frame_err)  n_ferr++;
            if (o_parity_err) n_perr++;
            if (o_overrun)    n_ovr++;
            if (o_data_valid) n_vld++;
            if (o_data_valid && i_data_ready) got_q.push_back(o_data);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        n_ferr = 0; n_perr = 0; n_ovr = 0; n_vld = 0;
        got_q.delete();
    endtask

    // Drive one serial frame: start, data LSB first, optional parity, stop
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
        logic pbit;
        pbit = (^d) ^ 1'(PARITY_ODD) ^ par_flip;
        i_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) begin
            i_rx = d[i];
            wait_clks(BIT_CLKS);
        end
        if (PAR_EN) begin
            i_rx = pbit;
            wait_clks(BIT_CLKS);
        end
        i_rx = stop_ok;
        wait_clks(BIT_CLKS);
        i_rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_rx = 1'b1; i_data_ready = 1'b0;
        wait_clks(5);
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
        checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_data_valid); end
        checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        checks++; if (o_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", o_parity_err); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", o_overrun); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_fifo_count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_fifo_count); end
        i_rst = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_basic();
        clear_mon();
        i_data_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(10);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_words: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_q[0]); end
        end
        checks++; if (n_vld !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", n_vld); end
        checks++; if ((n_ferr + n_perr + n_ovr) !== 0) begin errors++; $display("FAIL basic_flags: got %0d want 0", n_ferr + n_perr + n_ovr); end
    endtask

    task automatic test_glitch();
        clear_mon();
        i_rx = 1'b0;
        wait_clks(6);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", o_busy); end
        wait_clks(3 * CLK_DIV - 6);
        i_rx = 1'b1;
        wait_clks(100);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", o_busy); end
        checks++; if (o_fifo_count !== 0) begin errors++; $display("FAIL glitch_count: got %0d want 0", o_fifo_count); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_words: got %0d want 0", got_q.size()); end
        checks++; if ((n_ferr + n_perr + n_ovr) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d want 0", n_ferr + n_perr + n_ovr); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        i_data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(10);
        checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr); end
        checks++; if (o_fifo_count !== 0) begin errors++; $display("FAIL ferr_count: got %0d want 0", o_fifo_count); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_words: got %0d want 0", got_q.size()); end
        send_frame(8'h11, 1'b1, 1'b0);
        wait_clks(10);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_words: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h11) begin errors++; $display("FAIL ferr_next_data: got %h want 11", got_q[0]); end
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        i_data_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
        wait_clks(10);
        checks++; if (o_fifo_count !== FIFO_DEPTH) begin errors++; $display("FAIL ovr_count: got %0d want %0d", o_fifo_count, FIFO_DEPTH); end
        checks++; if (n_ovr !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr); end
        checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL ovr_head: got %h want 01", o_data); end
        i_data_ready = 1'b1;
        wait_clks(10);
        checks++; if (got_q.size() !== FIFO_DEPTH) begin errors++; $display("FAIL ovr_drain_words: got %0d want %0d", got_q.size(), FIFO_DEPTH); end
        else begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                checks++; if (got_q[k] !== 8'(k + 1)) begin errors++; $display("FAIL ovr_drain_%0d: got %h want %h", k, got_q[k], 8'(k + 1)); end
            end
        end
        checks++; if (o_fifo_count !== 0) begin errors++; $display("FAIL ovr_drain_count: got %0d want 0", o_fifo_count); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        i_data_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(10);
        checks++; if (n_perr !== 1) begin errors++; $display("FAIL par_bad_pulses: got %0d want 1", n_perr); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL par_bad_words: got %0d want 0", got_q.size()); end
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(10);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL par_good_words: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h want 07", got_q[0]); end
        end
        checks++; if (n_perr !== 1) begin errors++; $display("FAIL par_good_pulses: got %0d want 1", n_perr); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_mon();
        i_data_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        wait_clks(5);
        checks++; if (o_fifo_count !== 1) begin errors++; $display("FAIL rstmid_preload: got %0d want 1", o_fifo_count); end
        d = 8'h33;
        i_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            i_rx = d[i];
            wait_clks(BIT_CLKS);
        end
        i_rx = d[4];
        wait_clks(BIT_CLKS / 2);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", o_busy); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_data_valid); end
        checks++; if (o_fifo_count !== 0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", o_fifo_count); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", o_data); end
        i_rx = 1'b1;
        wait_clks(5);
        i_rst = 1'b0;
        clear_mon();
        i_data_ready = 1'b1;
        wait_clks(2 * BIT_CLKS);
        checks++; if ((got_q.size() !== 0) || (o_busy !== 1'b0)) begin errors++; $display("FAIL rstmid_no_recover: got words=%0d busy=%b want 0/0", got_q.size(), o_busy); end
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(10);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_next_words: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h want 5a", got_q[0]); end
        end
    endtask

    // Random frames against a queue model of what the receiver must deliver
    task automatic test_random();
        logic [7:0] exp_q [$];
        int exp_ferr, exp_perr;
        logic [7:0] d;
        bit st, pf;
        exp_ferr = 0; exp_perr = 0;
        clear_mon();
        i_data_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            pf = ($urandom_range(0, 3) == 0);
            send_frame(d, st, pf);
            if (PAR_EN && pf) exp_perr++;
            if (!st) exp_ferr++;
            if (st && !(PAR_EN && pf)) exp_q.push_back(d);
            wait_clks($urandom_range(0, 40));
        end
        wait_clks(BIT_CLKS);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_words: got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_data_%0d: got %h want %h", k, got_q[k], exp_q[k]); end
            end
        end
        checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL rand_ferr: got %0d want %0d", n_ferr, exp_ferr); end
        checks++; if (n_perr !== exp_perr) begin errors++; $display("FAIL rand_perr: got %0d want %0d", n_perr, exp_perr); end
        checks++; if (n_ovr !== 0) begin errors++; $display("FAIL rand_ovr: got %0d want 0", n_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
